// File: rtl/sram_1rw1r_wmask_model.sv
// Behavioural model of a single-clock 1RW+1R SRAM with a per-byte write mask.
// Port 0 reads or writes and port 1 only reads. Read latency is 1 or 2 edges.
// Port 0 can optionally return the merged word on a write (write-first).
// Port 1 flags when it reads an address that port 0 writes on the same edge.
// After reset an optional sweep zeroes every word, one word per edge.
module sram_1rw1r_wmask_model #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 6,
  parameter int RAM_DEPTH      = 1 << ADDR_WIDTH,
  parameter int WMASK_WIDTH    = DATA_WIDTH / 8,
  parameter int READ_LATENCY   = 1,
  parameter int WRITE_FIRST    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                   clk0,
  input  logic                   rstb0,
  input  logic                   csb0,
  input  logic                   web0,
  input  logic [WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0]  din0,
  output logic [DATA_WIDTH-1:0]  dout0,
  output logic                   dout0_vld,
  input  logic                   csb1,
  input  logic [ADDR_WIDTH-1:0]  addr1,
  output logic [DATA_WIDTH-1:0]  dout1,
  output logic                   dout1_vld,
  output logic                   collision1,
  output logic                   init_busy
);

  typedef enum logic {ST_CLEAR, ST_READY} init_state_e;

  // The depth is widened by one bit, so it can be compared with addresses even when RAM_DEPTH == 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT   = (ADDR_WIDTH + 1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam init_state_e           RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

  init_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;

  // Stage-1 registers. They only feed the outputs when READ_LATENCY == 2.
  logic                  s1_vld0_q, s1_vld0_d;
  logic [DATA_WIDTH-1:0] s1_dat0_q, s1_dat0_d;
  logic                  s1_vld1_q, s1_vld1_d;
  logic [DATA_WIDTH-1:0] s1_dat1_q, s1_dat1_d;
  logic                  s1_col1_q, s1_col1_d;

  logic [DATA_WIDTH-1:0] dout0_q, dout0_d;
  logic                  dout0_vld_q, dout0_vld_d;
  logic [DATA_WIDTH-1:0] dout1_q, dout1_d;
  logic                  dout1_vld_q, dout1_vld_d;
  logic                  col1_q, col1_d;

  logic                  ready, rd0, wr0, acc1, in0, in1;
  logic [DATA_WIDTH-1:0] old0, merged0;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  f_vld0, f_vld1, f_col1;
  logic [DATA_WIDTH-1:0] f_dat0, f_dat1;
  logic                  p_vld0, p_vld1, p_col1;
  logic [DATA_WIDTH-1:0] p_dat0, p_dat1;

  // Access decode, byte merge, the single array write port and front-of-pipe read data.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    merged0   = '0;

    ready = (state_q == ST_READY);
    rd0   = ready && !csb0 && web0;
    wr0   = ready && !csb0 && !web0;
    acc1  = ready && !csb1;
    in0   = ({1'b0, addr0} < DEPTH_EXT);
    in1   = ({1'b0, addr1} < DEPTH_EXT);

    // The array is read before this edge's write, so port 1 sees the pre-write word on a collision.
    old0   = in0 ? mem_q[addr0] : '0;
    f_dat1 = in1 ? mem_q[addr1] : '0;

    for (int i = 0; i < WMASK_WIDTH; i++) begin
      merged0[8*i +: 8] = wmask0[i] ? din0[8*i +: 8] : old0[8*i +: 8];
    end

    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = sweep_q;
    end else if (wr0 && in0) begin
      mem_we    = 1'b1;
      mem_waddr = addr0;
      mem_wdata = merged0;
    end

    f_vld0 = rd0 || (wr0 && (WRITE_FIRST != 0));
    f_dat0 = wr0 ? (in0 ? merged0 : '0) : old0;
    f_vld1 = acc1;
    f_col1 = acc1 && wr0 && in0 && (addr0 == addr1);
  end

  // Init sweep FSM, the optional second read stage, and output hold logic.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == ST_CLEAR) begin
      sweep_d = sweep_q + ADDR_WIDTH'(1);
      if (sweep_q == LAST_ADDR) begin
        state_d = ST_READY;
        sweep_d = '0;
      end
    end

    s1_vld0_d = f_vld0;
    s1_dat0_d = f_dat0;
    s1_vld1_d = f_vld1;
    s1_dat1_d = f_dat1;
    s1_col1_d = f_col1;

    p_vld0 = (READ_LATENCY == 1) ? f_vld0 : s1_vld0_q;
    p_dat0 = (READ_LATENCY == 1) ? f_dat0 : s1_dat0_q;
    p_vld1 = (READ_LATENCY == 1) ? f_vld1 : s1_vld1_q;
    p_dat1 = (READ_LATENCY == 1) ? f_dat1 : s1_dat1_q;
    p_col1 = (READ_LATENCY == 1) ? f_col1 : s1_col1_q;

    dout0_d     = p_vld0 ? p_dat0 : dout0_q;
    dout0_vld_d = p_vld0;
    dout1_d     = p_vld1 ? p_dat1 : dout1_q;
    dout1_vld_d = p_vld1;
    col1_d      = p_vld1 && p_col1;
  end

  // State, sweep counter, pipeline and output registers with asynchronous reset.
  // NOTE: non-blocking assignments make every flop sample pre-edge values, whatever the statement order.
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      state_q     <= RESET_STATE;
      sweep_q     <= '0;
      s1_vld0_q   <= 1'b0;
      s1_dat0_q   <= '0;
      s1_vld1_q   <= 1'b0;
      s1_dat1_q   <= '0;
      s1_col1_q   <= 1'b0;
      dout0_q     <= '0;
      dout0_vld_q <= 1'b0;
      dout1_q     <= '0;
      dout1_vld_q <= 1'b0;
      col1_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      s1_vld0_q   <= s1_vld0_d;
      s1_dat0_q   <= s1_dat0_d;
      s1_vld1_q   <= s1_vld1_d;
      s1_dat1_q   <= s1_dat1_d;
      s1_col1_q   <= s1_col1_d;
      dout0_q     <= dout0_d;
      dout0_vld_q <= dout0_vld_d;
      dout1_q     <= dout1_d;
      dout1_vld_q <= dout1_vld_d;
      col1_q      <= col1_d;
    end
  end

  // Array write port. The contents survive reset, and the sweep clears them instead.
  // NOTE: the array has no reset branch, so it maps to plain storage without a reset tree.
  always_ff @(posedge clk0) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign dout0      = dout0_q;
  assign dout0_vld  = dout0_vld_q;
  assign dout1      = dout1_q;
  assign dout1_vld  = dout1_vld_q;
  assign collision1 = col1_q;
  assign init_busy  = (state_q == ST_CLEAR);

endmodule
